// File: rtl/scan_seq_ctrl_if.sv
// ============================================================================
// Module   : scan_seq_ctrl_if
// Purpose  : Bundles the console handshake and the scanner fan-out of the
//            area-scan sequencer.
//            slave  = the sequencer's view.
//            master = the parent / console view.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface scan_seq_ctrl_if #(
    parameter int N_AREA = 4,
    parameter int BASE_W = 12
);
    // Console side
    logic                i_start_con;
    logic [BASE_W-1:0]   im_base_addr;
    logic [N_AREA-1:0]   im_area_en;
    logic                o_done_con;
    logic                o_error_con;
    logic                o_busy;
    logic [N_AREA-1:0]   om_err_vec;
    logic [N_AREA-1:0]   om_tmo_vec;

    // Scanner side
    logic [N_AREA-1:0]   om_start;
    logic [N_AREA-1:0]   im_done;
    logic [N_AREA-1:0]   im_error;
    logic [N_AREA-1:0]   om_grant;
    logic [BASE_W-1:0]   om_base_addr;

    modport slave (
        input  i_start_con, im_base_addr, im_area_en, im_done, im_error,
        output o_done_con, o_error_con, o_busy, om_err_vec, om_tmo_vec,
               om_start, om_grant, om_base_addr
    );

    modport master (
        output i_start_con, im_base_addr, im_area_en, im_done, im_error,
        input  o_done_con, o_error_con, o_busy, om_err_vec, om_tmo_vec,
               om_start, om_grant, om_base_addr
    );
endinterface

`default_nettype wire

// File: rtl/scan_seq_ctrl.sv
// ============================================================================
// Module   : scan_seq_ctrl
// Purpose  : Area-scan sequencer.
//            Runs the enabled area scanners one at a time, lowest index first.
//            For each scanner it issues a start pulse and holds a one-hot grant.
//            It waits for done under a watchdog and records per-area error and
//            timeout flags.
//            It can optionally abort the sequence on the first error.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module scan_seq_ctrl #(
    parameter int N_AREA       = 4,
    parameter int BASE_W       = 12,
    parameter int TMO_W        = 16,
    parameter int TMO_CYC      = 50000,
    parameter int ABORT_ON_ERR = 1
) (
    input  logic            clk,
    input  logic            rst,     // asynchronous, active-low
    scan_seq_ctrl_if.slave  bus
);

    localparam int                IDX_W      = (N_AREA > 1) ? $clog2(N_AREA) : 1;
    localparam logic [TMO_W-1:0]  C_CNT_LAST = TMO_W'(TMO_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [TMO_W-1:0]   cnt_q,   cnt_d;
    logic [N_AREA-1:0]  pend_q,  pend_d;
    logic [BASE_W-1:0]  base_q,  base_d;
    logic [N_AREA-1:0]  err_q,   err_d;
    logic [N_AREA-1:0]  tmo_q,   tmo_d;
    logic               errc_q,  errc_d;

    logic [IDX_W-1:0]   low_idx;
    logic [N_AREA-1:0]  sel_oh;
    logic               evt;
    logic               evt_err;

    // Lowest pending area: scan downwards so the last hit is the lowest index.
    always_comb begin
        low_idx = '0;
        for (int i = N_AREA - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    // One-hot decode of the active area index.
    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < N_AREA; i++) begin
            sel_oh[i] = (idx_q == IDX_W'(i));
        end
    end

    // Next-state logic.
    // A done from the active scanner takes priority over a timeout in the
    // same cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        base_d  = base_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        errc_d  = errc_q;
        evt     = 1'b0;
        evt_err = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.i_start_con) begin
                    pend_d  = bus.im_area_en;
                    base_d  = bus.im_base_addr;
                    err_d   = '0;
                    tmo_d   = '0;
                    errc_d  = 1'b0;
                    state_d = S_SELECT;
                end
            end

            S_SELECT: begin
                if (pend_q == '0) begin
                    errc_d  = |err_q;
                    state_d = S_FINISH;
                end else begin
                    idx_d   = low_idx;
                    state_d = S_START;
                end
            end

            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // Saturate instead of wrapping.
                if (cnt_q != C_CNT_LAST) begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
                if (bus.im_done[idx_q]) begin
                    evt            = 1'b1;
                    evt_err        = bus.im_error[idx_q];
                    err_d[idx_q]   = bus.im_error[idx_q];
                    pend_d[idx_q]  = 1'b0;
                end else if (cnt_q == C_CNT_LAST) begin
                    evt            = 1'b1;
                    evt_err        = 1'b1;
                    err_d[idx_q]   = 1'b1;
                    tmo_d[idx_q]   = 1'b1;
                    pend_d[idx_q]  = 1'b0;
                end
                if (evt) begin
                    if ((ABORT_ON_ERR != 0) && evt_err) begin
                        errc_d  = |err_d;
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_SELECT;
                    end
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= '0;
            base_q  <= '0;
            err_q   <= '0;
            tmo_q   <= '0;
            errc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            base_q  <= base_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            errc_q  <= errc_d;
        end
    end

    // Grant covers START plus every WAIT cycle and drops as WAIT is left.
    assign bus.om_start     = (state_q == S_START) ? sel_oh : '0;
    assign bus.om_grant     = ((state_q == S_START) || (state_q == S_WAIT)) ? sel_oh : '0;
    assign bus.o_done_con   = (state_q == S_FINISH);
    assign bus.o_busy       = (state_q != S_IDLE);
    assign bus.o_error_con  = errc_q;
    assign bus.om_base_addr = base_q;
    assign bus.om_err_vec   = err_q;
    assign bus.om_tmo_vec   = tmo_q;

endmodule

`default_nettype wire

// File: tb/tb_scan_seq_ctrl.sv
// ============================================================================
// Module   : tb_scan_seq_ctrl
// Purpose  : Bench for scan_seq_ctrl.
//            Runs two instances side by side: one with abort-on-error and one
//            without.
//            A schedule model predicts every output cycle by cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_scan_seq_ctrl;

    localparam int NA  = 4;
    localparam int BW  = 12;
    localparam int TMO = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Console stimulus and scanner behaviour configuration
    logic          start_con = 1'b0;
    logic [BW-1:0] base_in   = '0;
    logic [NA-1:0] en_in     = '0;
    logic [NA-1:0] errv      = '0;
    int            lat [NA];
    logic [NA-1:0] done_resp [2];
    logic [NA-1:0] done_inj  [2];
    int            cnt [2][NA];

    // Mirrored DUT outputs (index 0: abort, 1: no abort)
    logic [NA-1:0] o_start [2], o_grant [2], o_err [2], o_tmo [2];
    logic          o_done [2], o_ec [2], o_busy [2];
    logic [BW-1:0] o_base [2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    scan_seq_ctrl_if #(.N_AREA(NA), .BASE_W(BW)) if_a ();
    scan_seq_ctrl_if #(.N_AREA(NA), .BASE_W(BW)) if_b ();

    scan_seq_ctrl #(.N_AREA(NA), .BASE_W(BW), .TMO_W(16), .TMO_CYC(TMO), .ABORT_ON_ERR(1))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    scan_seq_ctrl #(.N_AREA(NA), .BASE_W(BW), .TMO_W(16), .TMO_CYC(TMO), .ABORT_ON_ERR(0))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));

    assign if_a.i_start_con  = start_con;
    assign if_a.im_base_addr = base_in;
    assign if_a.im_area_en   = en_in;
    assign if_a.im_error     = errv;
    assign if_a.im_done      = done_resp[0] | done_inj[0];
    assign if_b.i_start_con  = start_con;
    assign if_b.im_base_addr = base_in;
    assign if_b.im_area_en   = en_in;
    assign if_b.im_error     = errv;
    assign if_b.im_done      = done_resp[1] | done_inj[1];

    assign o_start[0] = if_a.om_start;     assign o_start[1] = if_b.om_start;
    assign o_grant[0] = if_a.om_grant;     assign o_grant[1] = if_b.om_grant;
    assign o_err[0]   = if_a.om_err_vec;   assign o_err[1]   = if_b.om_err_vec;
    assign o_tmo[0]   = if_a.om_tmo_vec;   assign o_tmo[1]   = if_b.om_tmo_vec;
    assign o_done[0]  = if_a.o_done_con;   assign o_done[1]  = if_b.o_done_con;
    assign o_ec[0]    = if_a.o_error_con;  assign o_ec[1]    = if_b.o_error_con;
    assign o_busy[0]  = if_a.o_busy;       assign o_busy[1]  = if_b.o_busy;
    assign o_base[0]  = if_a.om_base_addr; assign o_base[1]  = if_b.om_base_addr;

    task automatic chk(string name, int c, logic [31:0] act, logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s ch%0d cycle %0d: got %0h expected %0h", name, c, cyc, act, exp_v);
        end
    endtask

    // ------------------------------------------------------------------
    // Schedule model.
    // At an accepted start it lays out each enabled area's start and end
    // cycles, the recorded flags and the final done cycle.
    // ------------------------------------------------------------------
    bit            abort_cfg [2] = '{1'b1, 1'b0};
    bit            planned [2];
    int            t0 [2], fin [2];
    int            s_a [2][NA], e_a [2][NA];
    logic [NA-1:0] ran [2], rerr [2], rtmo [2];
    logic [BW-1:0] pbase [2], hbase [2];
    logic [NA-1:0] herr [2], htmo [2];
    logic          hec [2];

    task automatic make_plan(int c, int k);
        int t;
        bit stop;
        bit er;
        if (planned[c]) begin
            herr[c]  = rerr[c];
            htmo[c]  = rtmo[c];
            hec[c]   = |rerr[c];
            hbase[c] = pbase[c];
        end
        t0[c]    = k;
        pbase[c] = base_in;
        ran[c]   = '0;
        rerr[c]  = '0;
        rtmo[c]  = '0;
        t        = k + 1;             // first SELECT cycle
        stop     = 1'b0;
        fin[c]   = 0;
        for (int a = 0; a < NA; a++) begin
            if (!stop && en_in[a]) begin
                ran[c][a] = 1'b1;
                s_a[c][a] = t + 1;
                if (lat[a] > 0 && lat[a] <= TMO) begin
                    e_a[c][a] = t + 1 + lat[a];
                    er        = errv[a];
                end else begin
                    e_a[c][a]  = t + 1 + TMO;
                    er         = 1'b1;
                    rtmo[c][a] = 1'b1;
                end
                rerr[c][a] = er;
                t          = e_a[c][a] + 1;
                if (abort_cfg[c] && er) begin
                    stop   = 1'b1;
                    fin[c] = t;
                end
            end
        end
        if (!stop) fin[c] = t + 1;
        planned[c] = 1'b1;
    endtask

    function automatic void expect_at(int c, int k,
                                      output logic [NA-1:0] st, output logic [NA-1:0] gr,
                                      output logic [NA-1:0] ev, output logic [NA-1:0] tv,
                                      output logic dn, output logic bz, output logic ec,
                                      output logic [BW-1:0] bs);
        st = '0; gr = '0; ev = '0; tv = '0; dn = 1'b0; bz = 1'b0; ec = 1'b0; bs = '0;
        if (!planned[c]) return;
        if (k <= t0[c]) begin
            ev = herr[c]; tv = htmo[c]; ec = hec[c]; bs = hbase[c];
            return;
        end
        bs = pbase[c];
        bz = (k <= fin[c]);
        dn = (k == fin[c]);
        ec = (k >= fin[c]) ? |rerr[c] : 1'b0;
        for (int a = 0; a < NA; a++) begin
            if (ran[c][a]) begin
                if (k == s_a[c][a]) st[a] = 1'b1;
                if (k >= s_a[c][a] && k <= e_a[c][a]) gr[a] = 1'b1;
                if (k > e_a[c][a]) begin
                    ev[a] = rerr[c][a];
                    tv[a] = rtmo[c][a];
                end
            end
        end
    endfunction

    // Observation bookkeeping used by the directed checks
    int            td [2], fs [2];
    logic [NA-1:0] seen [2], gseen [2], fsb [2];

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin : p_model
        logic [NA-1:0] st, gr, ev, tv;
        logic          dn, bz, ec;
        logic [BW-1:0] bs;
        if (!rst) begin
            for (int c = 0; c < 2; c++) begin
                planned[c] = 1'b0;
                herr[c] = '0; htmo[c] = '0; hec[c] = 1'b0; hbase[c] = '0;
            end
        end
        for (int c = 0; c < 2; c++) begin
            expect_at(c, cyc, st, gr, ev, tv, dn, bz, ec, bs);
            chk("om_start",     c, 32'(o_start[c]), 32'(st));
            chk("om_grant",     c, 32'(o_grant[c]), 32'(gr));
            chk("om_err_vec",   c, 32'(o_err[c]),   32'(ev));
            chk("om_tmo_vec",   c, 32'(o_tmo[c]),   32'(tv));
            chk("o_done_con",   c, 32'(o_done[c]),  32'(dn));
            chk("o_busy",       c, 32'(o_busy[c]),  32'(bz));
            chk("o_error_con",  c, 32'(o_ec[c]),    32'(ec));
            chk("om_base_addr", c, 32'(o_base[c]),  32'(bs));
            seen[c]  = seen[c]  | o_start[c];
            gseen[c] = gseen[c] | o_grant[c];
            if (o_start[c] != '0 && fs[c] < 0) begin
                fs[c]  = cyc;
                fsb[c] = o_start[c];
            end
            if (o_done[c] && td[c] < 0) td[c] = cyc;
            if (rst && start_con && (!planned[c] || cyc > fin[c])) make_plan(c, cyc);
        end
        cyc++;
    end

    // Scanner responders.
    // Each one answers done lat[a] cycles after its start pulse; lat 0
    // means the scanner never answers.
    always @(negedge clk) begin : p_resp
        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < NA; a++) begin
                if (!rst) begin
                    cnt[c][a]       = 0;
                    done_resp[c][a] = 1'b0;
                end else begin
                    done_resp[c][a] = (cnt[c][a] == 1);
                    if (cnt[c][a] > 0) cnt[c][a] = cnt[c][a] - 1;
                    if (o_start[c][a] && lat[a] > 0) cnt[c][a] = lat[a];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(logic [NA-1:0] en, logic [BW-1:0] base,
                           int l0, int l1, int l2, int l3, logic [NA-1:0] ev);
        en_in = en; base_in = base; errv = ev;
        lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
    endtask

    task automatic clear_track();
        for (int c = 0; c < 2; c++) begin
            td[c] = -1; fs[c] = -1; seen[c] = '0; gseen[c] = '0; fsb[c] = '0;
        end
    endtask

    task automatic pulse_start(output int t_acc);
        clear_track();
        start_con = 1'b1;
        t_acc     = cyc;
        tick();
        start_con = 1'b0;
    endtask

    task automatic wait_done(int budget);
        int i;
        i = 0;
        while (i < budget && (td[0] < 0 || td[1] < 0)) begin
            tick();
            i++;
        end
        chk("seq_done_within_budget", 0, 32'(td[0] >= 0 && td[1] >= 0), 32'd1);
        tick();
        tick();
    endtask

    initial begin : p_main
        int ta;
        done_inj[0] = '0;
        done_inj[1] = '0;
        clear_track();
        set_cfg('0, '0, 0, 0, 0, 0, '0);
        repeat (3) tick();
        chk("reset_busy",  0, 32'(o_busy[0]),  32'd0);
        chk("reset_grant", 0, 32'(o_grant[0]), 32'd0);
        chk("reset_base",  0, 32'(o_base[0]),  32'd0);
        rst = 1'b1;
        tick();

        // T1: all four areas, clean completion
        set_cfg(4'b1111, 12'h3A5, 10, 10, 10, 10, 4'b0000);
        pulse_start(ta);
        wait_done(400);
        for (int c = 0; c < 2; c++) begin
            chk("t1_first_start_lat", c, 32'(fs[c] - ta), 32'd2);
            chk("t1_first_start_bit", c, 32'(fsb[c]),     32'h1);
            chk("t1_done_cycle",      c, 32'(td[c] - ta), 32'd50);
            chk("t1_starts_seen",     c, 32'(seen[c]),    32'hF);
            chk("t1_err_vec",         c, 32'(o_err[c]),   32'h0);
            chk("t1_error_con",       c, 32'(o_ec[c]),    32'h0);
        end

        // T2: sparse mask, then empty mask
        set_cfg(4'b1010, 12'h0F0, 10, 10, 10, 10, 4'b0000);
        pulse_start(ta);
        wait_done(400);
        for (int c = 0; c < 2; c++) begin
            chk("t2_starts_seen", c, 32'(seen[c]),  32'hA);
            chk("t2_grants_seen", c, 32'(gseen[c]), 32'hA);
        end
        set_cfg(4'b0000, 12'h00F, 10, 10, 10, 10, 4'b0000);
        pulse_start(ta);
        wait_done(50);
        for (int c = 0; c < 2; c++) begin
            chk("t2_empty_done_cycle", c, 32'(td[c] - ta), 32'd2);
            chk("t2_empty_no_start",   c, 32'(seen[c]),    32'h0);
        end

        // T3: area1 reports an error
        set_cfg(4'b1111, 12'h555, 10, 10, 10, 10, 4'b0010);
        pulse_start(ta);
        wait_done(400);
        chk("t3_abort_done_cycle", 0, 32'(td[0] - ta), 32'd25);
        chk("t3_abort_starts",     0, 32'(seen[0]),    32'h3);
        chk("t3_noabort_done",     1, 32'(td[1] - ta), 32'd50);
        chk("t3_noabort_starts",   1, 32'(seen[1]),    32'hF);
        for (int c = 0; c < 2; c++) begin
            chk("t3_err_vec",   c, 32'(o_err[c]), 32'h2);
            chk("t3_error_con", c, 32'(o_ec[c]),  32'h1);
        end

        // T4: area2 never answers
        set_cfg(4'b1111, 12'h123, 10, 10, 0, 10, 4'b0000);
        pulse_start(ta);
        wait_done(400);
        chk("t4_abort_done_cycle", 0, 32'(td[0] - ta), 32'd47);
        chk("t4_abort_starts",     0, 32'(seen[0]),    32'h7);
        chk("t4_noabort_starts",   1, 32'(seen[1]),    32'hF);
        for (int c = 0; c < 2; c++) begin
            chk("t4_tmo_vec",   c, 32'(o_tmo[c]), 32'h4);
            chk("t4_err_vec",   c, 32'(o_err[c]), 32'h4);
            chk("t4_error_con", c, 32'(o_ec[c]),  32'h1);
        end

        // T5 injects, at fixed offsets from acceptance:
        //   done and timeout together on area0;
        //   a stray done[3];
        //   a start while busy;
        //   a done during area3's START cycle.
        set_cfg(4'b1001, 12'hABC, 20, 10, 10, 10, 4'b0000);
        pulse_start(ta);                     // now in cycle ta+1
        repeat (4) tick();                   // ta+5, area0 in WAIT
        done_inj[0] = 4'b1000; done_inj[1] = 4'b1000;
        tick();
        done_inj[0] = '0; done_inj[1] = '0;
        repeat (2) tick();                   // ta+8
        start_con = 1'b1; base_in = 12'hFFF; en_in = 4'b0010;
        tick();                              // ta+9
        start_con = 1'b0;
        repeat (15) tick();                  // ta+24, area3 START
        done_inj[0] = 4'b1000; done_inj[1] = 4'b1000;
        tick();
        done_inj[0] = '0; done_inj[1] = '0;
        wait_done(400);
        for (int c = 0; c < 2; c++) begin
            chk("t5_tmo_vec",    c, 32'(o_tmo[c]),   32'h0);
            chk("t5_err_vec",    c, 32'(o_err[c]),   32'h0);
            chk("t5_starts",     c, 32'(seen[c]),    32'h9);
            chk("t5_done_cycle", c, 32'(td[c] - ta), 32'd36);
            chk("t5_base_kept",  c, 32'(o_base[c]),  32'hABC);
        end

        // T6: reset during area1 WAIT, then a fresh run
        set_cfg(4'b1111, 12'h777, 10, 10, 10, 10, 4'b0000);
        pulse_start(ta);
        repeat (16) tick();                  // ta+17
        chk("t6_pre_grant", 0, 32'(o_grant[0]), 32'h2);
        rst = 1'b0;
        #1;
        chk("t6_async_clear", 0,
            32'({o_start[0], o_grant[0], o_err[0], o_tmo[0],
                 o_done[0], o_ec[0], o_busy[0], o_base[0]}), 32'd0);
        clear_track();
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("t6_no_done_after_reset", 0, 32'(td[0]), 32'hFFFF_FFFF);
        set_cfg(4'b1111, 12'h321, 10, 10, 10, 10, 4'b0000);
        pulse_start(ta);
        wait_done(400);
        for (int c = 0; c < 2; c++) begin
            chk("t6_restart_first_bit", c, 32'(fsb[c]),     32'h1);
            chk("t6_restart_done",      c, 32'(td[c] - ta), 32'd50);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : p_watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
